// File: rtl/sha256_core_mb.sv
`default_nettype none
// ============================================================================
// Module      : sha256_core_mb
// Description : Multi-block SHA-256 compression engine. Chains digests across
//               512-bit blocks, ROUNDS_PER_CYCLE rounds per clock, with an
//               internal K ROM and a 16-word rolling message schedule.
//               Optional SHA-224 mode when SHA256_SHA224_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_core_mb #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
`ifdef SHA256_SHA224_EN
    input  logic         mode_224,
`endif
    output logic [255:0] digest_out,
    output logic         digest_valid,
    output logic         busy
);

    localparam int         c_R        = ROUNDS_PER_CYCLE;
    localparam logic [5:0] c_STEP     = 6'(c_R);
    localparam logic [5:0] c_LAST_GRP = 6'(64 - c_R);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    localparam logic [255:0] c_IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
`ifdef SHA256_SHA224_EN
    localparam logic [255:0] c_IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`endif

    localparam logic [31:0] c_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    generate
        if (!(c_R == 1 || c_R == 2 || c_R == 4 || c_R == 8)) begin : g_bad_rounds
            $error("sha256_core_mb: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [0:0]   r_state;
    logic [5:0]   r_round;
    logic [31:0]  r_h [0:7];
    logic [31:0]  r_v [0:7];
    logic [31:0]  r_w [0:15];
    logic         r_last;
    logic         r_dvalid;
    logic [255:0] r_digest;
`ifdef SHA256_SHA224_EN
    logic         r_mode224;
`endif

    logic         w_accept;
    logic         w_final;
    logic [31:0]  w_iv     [0:7];
    logic [31:0]  w_h_base [0:7];
    logic [31:0]  w_h_new  [0:7];
    logic [31:0]  w_v_next [0:7];
    logic [31:0]  w_w_next [0:15];

    assign in_ready     = (r_state == c_S_IDLE);
    assign busy         = (r_state == c_S_RUN);
    assign digest_out   = r_digest;
    assign digest_valid = r_dvalid;
    assign w_accept     = in_valid && in_ready;
    assign w_final      = (r_state == c_S_RUN) && (r_round == c_LAST_GRP);

    // Chain value for the incoming block: IV on a new message, else running H.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
`ifdef SHA256_SHA224_EN
            w_iv[i] = mode_224 ? c_IV224[255 - 32*i -: 32] : c_IV256[255 - 32*i -: 32];
`else
            w_iv[i] = c_IV256[255 - 32*i -: 32];
`endif
            w_h_base[i] = in_first ? w_iv[i] : r_h[i];
            w_h_new[i]  = r_h[i] + w_v_next[i];
        end
    end

    // Schedule words t+16..t+16+R-1 may depend on each other, so they are
    // built into an extended window before the rounds consume W[t..t+R-1].
    always_comb begin : p_rounds
        logic [31:0] ext [0:15+c_R];
        logic [31:0] st  [0:7];
        logic [31:0] t1;
        logic [31:0] t2;
        for (int i = 0; i < 16; i++) begin
            ext[i] = r_w[i];
        end
        for (int j = 0; j < c_R; j++) begin
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        end
        for (int i = 0; i < 8; i++) begin
            st[i] = r_v[i];
        end
        t1 = '0;
        t2 = '0;
        for (int j = 0; j < c_R; j++) begin
            t1 = st[7] + bsig1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6]))
               + c_K[r_round + 6'(j)] + ext[j];
            t2 = bsig0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
            st[7] = st[6];
            st[6] = st[5];
            st[5] = st[4];
            st[4] = st[3] + t1;
            st[3] = st[2];
            st[2] = st[1];
            st[1] = st[0];
            st[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) begin
            w_v_next[i] = st[i];
        end
        for (int i = 0; i < 16; i++) begin
            w_w_next[i] = ext[i + c_R];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_S_IDLE;
            r_round  <= '0;
            r_last   <= 1'b0;
            r_dvalid <= 1'b0;
            r_digest <= '0;
`ifdef SHA256_SHA224_EN
            r_mode224 <= 1'b0;
`endif
            for (int i = 0; i < 8; i++) begin
                r_h[i] <= c_IV256[255 - 32*i -: 32];
                r_v[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
        end else if (w_accept) begin
            r_state  <= c_S_RUN;
            r_round  <= '0;
            r_last   <= in_last;
            r_dvalid <= 1'b0;
`ifdef SHA256_SHA224_EN
            if (in_first) begin
                r_mode224 <= mode_224;
            end
`endif
            for (int i = 0; i < 8; i++) begin
                r_h[i] <= w_h_base[i];
                r_v[i] <= w_h_base[i];
            end
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= in_block[511 - 32*i -: 32];
            end
        end else if (r_state == c_S_RUN) begin
            r_round <= r_round + c_STEP;
            for (int i = 0; i < 8; i++) begin
                r_v[i] <= w_v_next[i];
            end
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= w_w_next[i];
            end
            if (w_final) begin
                r_state <= c_S_IDLE;
                for (int i = 0; i < 8; i++) begin
                    r_h[i] <= w_h_new[i];
                end
                if (r_last) begin
                    r_dvalid <= 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        r_digest[255 - 32*i -: 32] <= w_h_new[i];
                    end
`ifdef SHA256_SHA224_EN
                    if (r_mode224) begin
                        r_digest[31:0] <= '0;
                    end
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_core_mb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_core_mb
// Description : Directed bench for sha256_core_mb; one instance per
//               ROUNDS_PER_CYCLE in {1,2,4,8}, exercised one at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_core_mb;

    localparam logic [511:0] c_BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] c_BLK_M1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] c_BLK_M2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] c_DIG_ABC = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [255:0] c_DIG_2B  = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
    };
`ifdef SHA256_SHA224_EN
    localparam logic [255:0] c_DIG_224 = {
        32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
        32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000
    };
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         iv_a  [4];
    logic         if_a  [4];
    logic         il_a  [4];
    logic [511:0] blk_a [4];
    logic         rdy_a [4];
    logic         dv_a  [4];
    logic         bsy_a [4];
    logic [255:0] dig_a [4];
`ifdef SHA256_SHA224_EN
    logic         m224_a [4];
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_core_mb #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .in_valid     (iv_a[g]),
            .in_ready     (rdy_a[g]),
            .in_block     (blk_a[g]),
            .in_first     (if_a[g]),
            .in_last      (il_a[g]),
`ifdef SHA256_SHA224_EN
            .mode_224     (m224_a[g]),
`endif
            .digest_out   (dig_a[g]),
            .digest_valid (dv_a[g]),
            .busy         (bsy_a[g])
        );
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [511:0] blk,
                         input logic first, input logic last);
        iv_a[d]  = v;
        blk_a[d] = blk;
        if_a[d]  = first;
        il_a[d]  = last;
    endtask

    // Count negedges with in_ready low, starting at the negedge after an accept.
    task automatic count_busy(input int d, output int cnt);
        cnt = 0;
        while (!rdy_a[d] && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_abc(input int d, input logic first, input logic [255:0] exp_dig, input string nm);
        int cnt;
        int lat;
        lat = 64 >> d;
        @(negedge clk);
        check($sformatf("%s R%0d ready", nm, 1 << d), 256'(rdy_a[d]), 256'(1));
        drive(d, 1'b1, c_BLK_ABC, first, 1'b1);
        @(negedge clk);
        iv_a[d] = 1'b0;
        check($sformatf("%s R%0d busy", nm, 1 << d), 256'(bsy_a[d]), 256'(1));
        check($sformatf("%s R%0d dv_low", nm, 1 << d), 256'(dv_a[d]), 256'(0));
        count_busy(d, cnt);
        check($sformatf("%s R%0d latency", nm, 1 << d), 256'(cnt), 256'(lat));
        check($sformatf("%s R%0d dv", nm, 1 << d), 256'(dv_a[d]), 256'(1));
        check($sformatf("%s R%0d digest", nm, 1 << d), dig_a[d], exp_dig);
    endtask

    task automatic run_two_block(input int d);
        int cnt;
        @(negedge clk);
        drive(d, 1'b1, c_BLK_M1, 1'b1, 1'b0);
        @(negedge clk);
        drive(d, 1'b1, c_BLK_M2, 1'b0, 1'b1);
        count_busy(d, cnt);
        check($sformatf("2blk R%0d b1 busy", 1 << d), 256'(cnt), 256'(64 >> d));
        check($sformatf("2blk R%0d b1 dv", 1 << d), 256'(dv_a[d]), 256'(0));
        @(negedge clk);
        iv_a[d] = 1'b0;
        count_busy(d, cnt);
        check($sformatf("2blk R%0d b2 busy", 1 << d), 256'(cnt), 256'(64 >> d));
        check($sformatf("2blk R%0d dv", 1 << d), 256'(dv_a[d]), 256'(1));
        check($sformatf("2blk R%0d digest", 1 << d), dig_a[d], c_DIG_2B);
        repeat (3) @(negedge clk);
        check($sformatf("2blk R%0d hold dv", 1 << d), 256'(dv_a[d]), 256'(1));
        check($sformatf("2blk R%0d hold dig", 1 << d), dig_a[d], c_DIG_2B);
    endtask

    task automatic run_b2b(input int d);
        int cnt;
        @(negedge clk);
        drive(d, 1'b1, c_BLK_ABC, 1'b1, 1'b1);
        @(negedge clk);
        count_busy(d, cnt);
        check($sformatf("b2b R%0d first busy", 1 << d), 256'(cnt), 256'(64 >> d));
        check($sformatf("b2b R%0d first dig", 1 << d), dig_a[d], c_DIG_ABC);
        check($sformatf("b2b R%0d first dv", 1 << d), 256'(dv_a[d]), 256'(1));
        @(negedge clk);
        iv_a[d] = 1'b0;
        check($sformatf("b2b R%0d dv drop", 1 << d), 256'(dv_a[d]), 256'(0));
        count_busy(d, cnt);
        check($sformatf("b2b R%0d second busy", 1 << d), 256'(cnt), 256'(64 >> d));
        check($sformatf("b2b R%0d second dig", 1 << d), dig_a[d], c_DIG_ABC);
    endtask

    task automatic run_reset_mid(input int d);
        @(negedge clk);
        drive(d, 1'b1, c_BLK_ABC, 1'b1, 1'b1);
        @(negedge clk);
        iv_a[d] = 1'b0;
        repeat (30 >> d) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check($sformatf("rst R%0d ready", 1 << d), 256'(rdy_a[d]), 256'(1));
        check($sformatf("rst R%0d busy", 1 << d), 256'(bsy_a[d]), 256'(0));
        check($sformatf("rst R%0d dv", 1 << d), 256'(dv_a[d]), 256'(0));
        check($sformatf("rst R%0d dig", 1 << d), dig_a[d], 256'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check($sformatf("rst R%0d no pulse", 1 << d), 256'(dv_a[d]), 256'(0));
        // first=0 straight after reset must chain from the reset IV
        run_abc(d, 1'b0, c_DIG_ABC, "rerun");
    endtask

    task automatic run_random(input int d);
        int exp_acc;
        int obs_acc;
        int cnt;
        logic prev_rdy;
        exp_acc = 0;
        obs_acc = 0;
        @(negedge clk);
        drive(d, 1'b0, c_BLK_ABC, 1'b1, 1'b1);
        prev_rdy = rdy_a[d];
        for (int k = 0; k < 4 * (64 >> d) + 10; k++) begin
            if (prev_rdy && !rdy_a[d]) obs_acc++;
            iv_a[d] = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (iv_a[d] && rdy_a[d]) exp_acc++;
            prev_rdy = rdy_a[d];
            @(negedge clk);
        end
        iv_a[d] = 1'b0;
        if (prev_rdy && !rdy_a[d]) obs_acc++;
        check($sformatf("rand R%0d accepts", 1 << d), 256'(obs_acc), 256'(exp_acc));
        count_busy(d, cnt);
        check($sformatf("rand R%0d settle", 1 << d), 256'(rdy_a[d]), 256'(1));
        check($sformatf("rand R%0d digest", 1 << d), dig_a[d], c_DIG_ABC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(i, 1'b0, '0, 1'b0, 1'b0);
`ifdef SHA256_SHA224_EN
            m224_a[i] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset R%0d ready", 1 << d), 256'(rdy_a[d]), 256'(1));
            check($sformatf("reset R%0d busy", 1 << d), 256'(bsy_a[d]), 256'(0));
            check($sformatf("reset R%0d dv", 1 << d), 256'(dv_a[d]), 256'(0));
            check($sformatf("reset R%0d dig", 1 << d), dig_a[d], 256'(0));
        end
        for (int d = 0; d < 4; d++) begin
            run_abc(d, 1'b1, c_DIG_ABC, "abc");
            run_two_block(d);
            run_b2b(d);
            run_reset_mid(d);
            run_random(d);
`ifdef SHA256_SHA224_EN
            m224_a[d] = 1'b1;
            run_abc(d, 1'b1, c_DIG_224, "sha224");
            m224_a[d] = 1'b0;
            run_abc(d, 1'b1, c_DIG_ABC, "back256");
`endif
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
